// File: rtl/philv_control_fsm_pkg.sv
// Shared encodings for the Philosophy-V multi-cycle control path: states, RV32I opcodes
// and the mux-select codes also used by the datapath and alu_decoder.
package philv_control_fsm_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JAL    = 2'd2;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IIMM = 2'd1;
   localparam logic [1:0] SRCB_SIMM = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef struct packed {
      logic legal;
      logic is_r;
      logic is_i;
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_jal;
   } op_class_t;

endpackage

// File: rtl/philv_control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// PHILV_CTRL_PERF_EN adds the cycle_cnt / instret performance counters.
interface philv_control_fsm_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alu_zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_wr_ena;
   logic       mem_addr_sel;
   logic       ir_ena;
   logic       pc_ena;
   logic [1:0] pc_src;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_wr_ena;
   logic [1:0] wb_src;
   logic       halted;
   logic       bus_err;
   logic [2:0] state;
`ifdef PHILV_CTRL_PERF_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instret;
`endif

   modport master (
      input  opcode, funct3, alu_zero, mem_ready,
      output mem_req, mem_wr_ena, mem_addr_sel, ir_ena, pc_ena, pc_src,
             alu_src_b, alu_op, reg_wr_ena, wb_src, halted, bus_err, state
`ifdef PHILV_CTRL_PERF_EN
      , output cycle_cnt, instret
`endif
   );

   modport slave (
      output opcode, funct3, alu_zero, mem_ready,
      input  mem_req, mem_wr_ena, mem_addr_sel, ir_ena, pc_ena, pc_src,
             alu_src_b, alu_op, reg_wr_ena, wb_src, halted, bus_err, state
`ifdef PHILV_CTRL_PERF_EN
      , input cycle_cnt, instret
`endif
   );
endinterface

// File: rtl/philv_control_fsm_opcode_class.sv
// Combinational RV32I opcode classifier used by the control sequencer.
import philv_control_fsm_pkg::*;

module philv_opcode_class (
   input  logic [6:0] opcode,
   output op_class_t  cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_R:      cls.is_r      = 1'b1;
         OP_I:      cls.is_i      = 1'b1;
         OP_LOAD:   cls.is_load   = 1'b1;
         OP_STORE:  cls.is_store  = 1'b1;
         OP_BRANCH: cls.is_branch = 1'b1;
         OP_JAL:    cls.is_jal    = 1'b1;
         default:   ;
      endcase
      cls.legal = cls.is_r | cls.is_i | cls.is_load | cls.is_store | cls.is_branch | cls.is_jal;
   end

endmodule

// File: rtl/philv_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Philosophy-V core with optional
// memory timeout; PHILV_CTRL_PERF_EN adds cycle_cnt and instret counters.
import philv_control_fsm_pkg::*;

module philv_control_fsm #(
   parameter int MEM_TIMEOUT = 0,
   parameter int TO_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   philv_control_fsm_if.master  bus
);

   state_t              state_q, state_d;
   logic [TO_WIDTH-1:0] to_cnt;
   logic                bus_err_q, bus_err_d;
   logic                mem_phase, timeout_hit;
   op_class_t           cls;

   philv_opcode_class u_class (
      .opcode (bus.opcode),
      .cls    (cls)
   );

   assign mem_phase   = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_phase && !bus.mem_ready &&
                        (to_cnt == TO_WIDTH'(MEM_TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         to_cnt    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bus_err_q <= bus_err_d;
         if ((MEM_TIMEOUT != 0) && mem_phase && !bus.mem_ready && !timeout_hit)
            to_cnt <= to_cnt + TO_WIDTH'(1);
         else
            to_cnt <= '0;
      end
   end

   always_comb begin
      state_d          = state_q;
      bus_err_d        = bus_err_q | timeout_hit;
      bus.mem_req      = 1'b0;
      bus.mem_wr_ena   = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.ir_ena       = 1'b0;
      bus.pc_ena       = 1'b0;
      bus.pc_src       = PC_PLUS4;
      bus.alu_src_b    = SRCB_RS2;
      bus.alu_op       = ALUOP_ADD;
      bus.reg_wr_ena   = 1'b0;
      bus.wb_src       = WB_ALU;
      bus.halted       = 1'b0;
      bus.bus_err      = bus_err_q;
      bus.state        = state_q;
      case (state_q)
         ST_FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_ena = 1'b1;
               bus.pc_ena = 1'b1;
               state_d    = ST_DECODE;
            end else if (timeout_hit) begin
               state_d = ST_HALT;
            end
         end
         ST_DECODE: state_d = cls.legal ? ST_EXEC : ST_HALT;
         ST_EXEC: begin
            state_d = ST_HALT;
            if (cls.is_r || cls.is_i) begin
               bus.alu_op    = ALUOP_FUNCT;
               bus.alu_src_b = cls.is_i ? SRCB_IIMM : SRCB_RS2;
               state_d       = ST_WB;
            end else if (cls.is_load || cls.is_store) begin
               bus.alu_src_b = cls.is_store ? SRCB_SIMM : SRCB_IIMM;
               state_d       = ST_MEM;
            end else if (cls.is_branch) begin
               bus.alu_op = ALUOP_SUB;
               bus.pc_ena = bus.alu_zero ^ bus.funct3[0];
               bus.pc_src = PC_BRANCH;
               state_d    = ST_FETCH;
            end else if (cls.is_jal) begin
               bus.pc_ena     = 1'b1;
               bus.pc_src     = PC_JAL;
               bus.reg_wr_ena = 1'b1;
               bus.wb_src     = WB_PC4;
               state_d        = ST_FETCH;
            end
         end
         ST_MEM: begin
            bus.mem_req      = 1'b1;
            bus.mem_addr_sel = 1'b1;
            bus.mem_wr_ena   = cls.is_store;
            if (bus.mem_ready)
               state_d = cls.is_load ? ST_WB : ST_FETCH;
            else if (timeout_hit)
               state_d = ST_HALT;
         end
         ST_WB: begin
            bus.reg_wr_ena = 1'b1;
            bus.wb_src     = cls.is_load ? WB_MEM : WB_ALU;
            state_d        = ST_FETCH;
         end
         ST_HALT: bus.halted = 1'b1;
         default: state_d = ST_HALT;
      endcase
      // Reset parks the FSM in FETCH; any request it would present is suppressed.
      if (rst) begin
         bus.mem_req = 1'b0;
         bus.ir_ena  = 1'b0;
         bus.pc_ena  = 1'b0;
      end
   end

`ifdef PHILV_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q, instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         if (state_q != ST_HALT)
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if ((state_d == ST_FETCH) &&
             ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)))
            instret_q <= instret_q + 32'd1;
      end
   end

   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.instret   = instret_q;
`endif

endmodule
